// File: rtl/velocity_cell_dbuf_if.sv
// velocity_cell_dbuf_if: read, append and swap signals of the double-buffered velocity memory
interface velocity_cell_dbuf_if #(
  parameter int COMP_WIDTH = 32,
  parameter int DATA_WIDTH = 3 * COMP_WIDTH,
  parameter int ADDR_WIDTH = 8
);
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;
  logic                  rd_oob;
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_ready;
  logic                  wr_overflow;
  logic                  swap;
  logic [ADDR_WIDTH:0]   active_count;
  logic [ADDR_WIDTH:0]   shadow_count;
  logic                  active_bank;
  modport master (
    output rd_en, rd_addr, wr_en, wr_data, swap,
    input  rd_data, rd_valid, rd_oob, wr_ready, wr_overflow, active_count, shadow_count, active_bank
  );
  modport slave (
    input  rd_en, rd_addr, wr_en, wr_data, swap,
    output rd_data, rd_valid, rd_oob, wr_ready, wr_overflow, active_count, shadow_count, active_bank
  );
endinterface

// File: rtl/velocity_cell_dbuf.sv
// velocity_cell_dbuf: two-bank per-cell velocity memory, reads from active bank, appends to shadow bank, swap exchanges them
module velocity_cell_dbuf #(
  parameter int COMP_WIDTH = 32,
  parameter int DATA_WIDTH = 3 * COMP_WIDTH,
  parameter int DEPTH      = 220,
  parameter int ADDR_WIDTH = 8
) (
  input logic                 clk,
  input logic                 rst,
  velocity_cell_dbuf_if.slave bus
);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] FULL = (ADDR_WIDTH + 1)'(DEPTH);
  logic [DATA_WIDTH-1:0] bank0 [DEPTH];
  logic [DATA_WIDTH-1:0] bank1 [DEPTH];
  logic                  active_bank;
  logic [ADDR_WIDTH:0]   active_count;
  logic [ADDR_WIDTH:0]   shadow_count;
  logic                  wr_overflow;
  logic                  full;
  logic                  wr_acc;
  logic [IW-1:0]         wr_idx;
  logic                  s1_valid;
  logic                  s1_oob;
  logic                  s1_bank;
  logic [IW-1:0]         s1_addr;
  logic                  rd_valid;
  logic                  rd_oob;
  logic [DATA_WIDTH-1:0] rd_data;
  assign full   = shadow_count == FULL;
  assign wr_acc = !rst && bus.wr_en && !full;
  assign wr_idx = shadow_count[IW-1:0];
  always_ff @(posedge clk)
    if (wr_acc && active_bank) bank0[wr_idx] <= bus.wr_data;
  always_ff @(posedge clk)
    if (wr_acc && !active_bank) bank1[wr_idx] <= bus.wr_data;
  always_ff @(posedge clk) begin
    if (rst) begin
      active_bank  <= 1'b0;
      active_count <= '0;
      shadow_count <= '0;
      wr_overflow  <= 1'b0;
    end else begin
      if (bus.wr_en && full) wr_overflow <= 1'b1;
      if (bus.swap) begin
        active_bank  <= !active_bank;
        active_count <= shadow_count + (ADDR_WIDTH + 1)'(wr_acc);
        shadow_count <= '0;
      end else if (wr_acc) begin
        shadow_count <= shadow_count + 1'b1;
      end
    end
  end
  always_ff @(posedge clk) begin
    s1_valid <= !rst && bus.rd_en;
    s1_oob   <= {1'b0, bus.rd_addr} >= active_count;
    s1_bank  <= active_bank;
    s1_addr  <= bus.rd_addr[IW-1:0];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid <= 1'b0;
      rd_oob   <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= s1_valid;
      rd_oob   <= s1_valid && s1_oob;
      rd_data  <= s1_oob ? '0 : s1_bank ? bank1[s1_addr] : bank0[s1_addr];
    end
  end
  assign bus.rd_valid     = rd_valid;
  assign bus.rd_oob       = rd_oob;
  assign bus.rd_data      = rd_data;
  assign bus.wr_ready     = !full;
  assign bus.wr_overflow  = wr_overflow;
  assign bus.active_count = active_count;
  assign bus.shadow_count = shadow_count;
  assign bus.active_bank  = active_bank;
endmodule

// File: tb/tb_velocity_cell_dbuf.sv
// tb_velocity_cell_dbuf: directed stimulus with a queued scoreboard checking read responses and status
module tb_velocity_cell_dbuf;
  localparam int CW = 16;
  localparam int DW = 3 * CW;
  localparam int DEPTH = 4;
  localparam int AW = 3;
  localparam logic [DW-1:0] A = 48'h0003_0002_0001;
  localparam logic [DW-1:0] B = 48'h0013_0012_0011;
  localparam logic [DW-1:0] C = 48'h0023_0022_0021;
  localparam logic [DW-1:0] D = 48'h0d03_0d02_0d01;
  localparam logic [DW-1:0] E = 48'h0e03_0e02_0e01;
  localparam logic [DW-1:0] F = 48'h0f03_0f02_0f01;
  localparam logic [DW-1:0] G = 48'h1003_1002_1001;
  localparam logic [DW-1:0] H = 48'h1103_1102_1101;
  localparam logic [DW-1:0] I = 48'h1203_1202_1201;
  localparam logic [DW-1:0] J = 48'h1303_1302_1301;
  localparam logic [DW-1:0] K = 48'h1403_1402_1401;
  localparam logic [DW-1:0] L = 48'h1503_1502_1501;
  localparam logic [DW-1:0] M = 48'h1603_1602_1601;
  localparam logic [DW-1:0] N = 48'h1703_1702_1701;
  localparam logic [DW-1:0] P = 48'h1803_1802_1801;
  localparam logic [DW-1:0] Q = 48'h1903_1902_1901;
  typedef struct {
    int            cyc;
    logic          oob;
    logic [DW-1:0] data;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int cyc = 0;
  int total = 0;
  int bad = 0;
  exp_t sb[$];
  velocity_cell_dbuf_if #(.COMP_WIDTH(CW), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();
  velocity_cell_dbuf #(.COMP_WIDTH(CW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (bus.rd_valid) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL rd_unexpected cyc=%0d got oob=%0b data=%h, required no response", cyc, bus.rd_oob, bus.rd_data);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (e.cyc != cyc || e.oob != bus.rd_oob || e.data != bus.rd_data) begin
          bad++;
          $display("FAIL rd_resp cyc=%0d got oob=%0b data=%h, required cyc=%0d oob=%0b data=%h",
                   cyc, bus.rd_oob, bus.rd_data, e.cyc, e.oob, e.data);
        end
      end
    end else if (sb.size() != 0 && sb[0].cyc <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      total++;
      bad++;
      $display("FAIL rd_missing cyc=%0d got rd_valid=0, required oob=%0b data=%h", cyc, e.oob, e.data);
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got %0h, required %0h", name, act, exp);
    end
  endtask
  task automatic quiet();
    bus.rd_en = 1'b0;
    bus.wr_en = 1'b0;
    bus.swap  = 1'b0;
  endtask
  task automatic wr(input logic [DW-1:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_data = d;
    tick();
    quiet();
  endtask
  task automatic swp();
    bus.swap = 1'b1;
    tick();
    quiet();
  endtask
  task automatic expect_rd(input logic [AW-1:0] a, input logic oob, input logic [DW-1:0] d);
    exp_t e;
    bus.rd_en   = 1'b1;
    bus.rd_addr = a;
    e.cyc  = cyc + 2;
    e.oob  = oob;
    e.data = d;
    sb.push_back(e);
  endtask
  task automatic rd(input logic [AW-1:0] a, input logic oob, input logic [DW-1:0] d);
    expect_rd(a, oob, d);
    tick();
    quiet();
  endtask
  task automatic drain();
    for (int i = 0; i < 4; i++) tick();
  endtask
  initial begin
    bus.rd_addr = '0;
    bus.wr_data = '0;
    quiet();
    tick();
    tick();
    check("rst_rd_valid", 64'(bus.rd_valid), 64'd0);
    check("rst_rd_data", 64'(bus.rd_data), 64'd0);
    check("rst_rd_oob", 64'(bus.rd_oob), 64'd0);
    rst = 1'b0;
    tick();
    check("rst_active_count", 64'(bus.active_count), 64'd0);
    check("rst_shadow_count", 64'(bus.shadow_count), 64'd0);
    check("rst_active_bank", 64'(bus.active_bank), 64'd0);
    check("rst_wr_ready", 64'(bus.wr_ready), 64'd1);
    check("rst_wr_overflow", 64'(bus.wr_overflow), 64'd0);
    rd(0, 1'b1, '0);
    drain();
    wr(A);
    wr(B);
    wr(C);
    check("fill_shadow_count", 64'(bus.shadow_count), 64'd3);
    check("fill_active_count_pre", 64'(bus.active_count), 64'd0);
    swp();
    check("fill_active_count", 64'(bus.active_count), 64'd3);
    check("fill_shadow_zero", 64'(bus.shadow_count), 64'd0);
    check("fill_active_bank", 64'(bus.active_bank), 64'd1);
    rd(0, 1'b0, A);
    rd(1, 1'b0, B);
    rd(2, 1'b0, C);
    rd(3, 1'b1, '0);
    drain();
    wr(E);
    wr(F);
    bus.wr_en   = 1'b1;
    bus.wr_data = D;
    bus.swap    = 1'b1;
    expect_rd(1, 1'b0, B);
    tick();
    quiet();
    check("coll_active_count", 64'(bus.active_count), 64'd3);
    check("coll_active_bank", 64'(bus.active_bank), 64'd0);
    check("coll_shadow_count", 64'(bus.shadow_count), 64'd0);
    rd(2, 1'b0, D);
    rd(0, 1'b0, E);
    rd(3, 1'b1, '0);
    drain();
    wr(G);
    wr(H);
    wr(I);
    check("ovf_ready_3", 64'(bus.wr_ready), 64'd1);
    wr(J);
    check("ovf_ready_4", 64'(bus.wr_ready), 64'd0);
    check("ovf_shadow_4", 64'(bus.shadow_count), 64'd4);
    check("ovf_flag_pre", 64'(bus.wr_overflow), 64'd0);
    wr(K);
    check("ovf_flag", 64'(bus.wr_overflow), 64'd1);
    check("ovf_shadow_held", 64'(bus.shadow_count), 64'd4);
    bus.wr_en   = 1'b1;
    bus.wr_data = L;
    bus.swap    = 1'b1;
    tick();
    quiet();
    check("ovf_active_count", 64'(bus.active_count), 64'd4);
    check("ovf_flag_sticky", 64'(bus.wr_overflow), 64'd1);
    check("ovf_active_bank", 64'(bus.active_bank), 64'd1);
    check("ovf_ready_after", 64'(bus.wr_ready), 64'd1);
    rd(3, 1'b0, J);
    rd(0, 1'b0, G);
    rd(4, 1'b1, '0);
    drain();
    wr(M);
    wr(N);
    swp();
    check("dbl_bank_1", 64'(bus.active_bank), 64'd0);
    check("dbl_count_1", 64'(bus.active_count), 64'd2);
    wr(P);
    swp();
    check("dbl_bank_2", 64'(bus.active_bank), 64'd1);
    check("dbl_count_2", 64'(bus.active_count), 64'd1);
    rd(0, 1'b0, P);
    rd(1, 1'b1, '0);
    drain();
    wr(Q);
    swp();
    check("b2b_count_1", 64'(bus.active_count), 64'd1);
    swp();
    check("b2b_count_2", 64'(bus.active_count), 64'd0);
    check("b2b_bank", 64'(bus.active_bank), 64'd1);
    rd(0, 1'b1, '0);
    drain();
    bus.rd_en   = 1'b1;
    bus.rd_addr = 0;
    tick();
    quiet();
    rst = 1'b1;
    tick();
    check("rstrd_valid_n2", 64'(bus.rd_valid), 64'd0);
    rst = 1'b0;
    tick();
    check("rstrd_valid_n3", 64'(bus.rd_valid), 64'd0);
    check("rstrd_bank", 64'(bus.active_bank), 64'd0);
    check("rstrd_overflow", 64'(bus.wr_overflow), 64'd0);
    check("rstrd_active_count", 64'(bus.active_count), 64'd0);
    drain();
    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
